// File: rtl/conn_table_loader.sv
// Connection table loader: fetches connection records from a config reader into a
// local table, then serves sequential first-match lookups by local QP.
module conn_table_loader #(
  parameter int MAX_ENTRIES    = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  input  logic        cfg_busy,
  input  logic [31:0] cfg_conn_count,
  output logic [5:0]  rd_index,
  output logic        rd_req,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_local_qp,
  input  logic [15:0] rsp_peer_qp,
  input  logic [31:0] rsp_peer_ip,
  input  logic [47:0] rsp_peer_mac,
  input  logic        rsp_up,
  input  logic        load_start,
  output logic        load_done,
  output logic        load_error,
  output logic [6:0]  entries_loaded,
  input  logic        lk_valid,
  input  logic [15:0] lk_qp,
  output logic        lk_busy,
  output logic        lk_done,
  output logic        lk_hit,
  output logic [15:0] lk_peer_qp,
  output logic [31:0] lk_peer_ip,
  output logic [47:0] lk_peer_mac
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_CFG = 3'd1;
  localparam logic [2:0] ISSUE    = 3'd2;
  localparam logic [2:0] WAIT_RSP = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;
  localparam logic [2:0] ERROR    = 3'd5;

  typedef struct packed {
    logic [15:0] local_qp;
    logic [15:0] peer_qp;
    logic [31:0] peer_ip;
    logic [47:0] peer_mac;
  } ent_t;

  ent_t                   tab [MAX_ENTRIES];
  logic [MAX_ENTRIES-1:0] tvld;
  logic [2:0]             state;
  logic [5:0]             i;
  logic [5:0]             lk_k;
  logic [6:0]             cnt;
  logic [TW-1:0]          tmo;
  logic [15:0]            qp_cap;
  logic [5:0]             wr_ptr;
  ent_t                   cur;
  logic                   lk_match;
  logic                   lk_last;
  logic                   rsp_take;

  assign load_done  = (state == DONE);
  assign load_error = (state == ERROR);
  assign wr_ptr     = entries_loaded[5:0];
  assign cur        = tab[lk_k];
  assign lk_match   = tvld[lk_k] && (cur.local_qp == qp_cap) && ({1'b0, lk_k} < entries_loaded);
  assign lk_last    = ({1'b0, lk_k} + 7'd1) >= entries_loaded;
  assign rsp_take   = (state == WAIT_RSP) && cfg_valid && rsp_valid;

  // Table payload carries no reset; tvld alone marks which slots are live.
  always_ff @(posedge clk) begin
    if (rsp_take && rsp_up)
      tab[wr_ptr] <= '{rsp_local_qp, rsp_peer_qp, rsp_peer_ip, rsp_peer_mac};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      i              <= '0;
      cnt            <= '0;
      tmo            <= '0;
      rd_req         <= 1'b0;
      rd_index       <= '0;
      entries_loaded <= '0;
      tvld           <= '0;
      lk_busy        <= 1'b0;
      lk_done        <= 1'b0;
      lk_hit         <= 1'b0;
      lk_peer_qp     <= '0;
      lk_peer_ip     <= '0;
      lk_peer_mac    <= '0;
      lk_k           <= '0;
      qp_cap         <= '0;
    end else begin
      rd_req  <= 1'b0;
      lk_done <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (load_start) begin
            entries_loaded <= '0;
            tvld           <= '0;
            i              <= '0;
            lk_busy        <= 1'b0;
            state          <= WAIT_CFG;
          end
        end
        WAIT_CFG: begin
          if (cfg_valid && !cfg_busy) begin
            if (cfg_conn_count > 32'(MAX_ENTRIES)) state <= ERROR;
            else if (cfg_conn_count == 32'd0)      state <= DONE;
            else begin
              cnt   <= cfg_conn_count[6:0];
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!cfg_valid) state <= ERROR;
          else if (!cfg_busy) begin
            rd_req   <= 1'b1;
            rd_index <= i;
            tmo      <= '0;
            state    <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (!cfg_valid) state <= ERROR;
          else if (rsp_valid) begin
            if (rsp_up) begin
              entries_loaded <= entries_loaded + 7'd1;
              tvld[wr_ptr]   <= 1'b1;
            end
            // Index stops at the last record so it never wraps past 63.
            if (({1'b0, i} + 7'd1) == cnt) state <= DONE;
            else begin
              i     <= i + 6'd1;
              state <= ISSUE;
            end
          end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) state <= ERROR;
          else tmo <= tmo + 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (state == DONE && !load_start) begin
        if (!lk_busy && lk_valid) begin
          lk_busy <= 1'b1;
          qp_cap  <= lk_qp;
          lk_k    <= '0;
        end else if (lk_busy) begin
          if (lk_match) begin
            lk_busy     <= 1'b0;
            lk_done     <= 1'b1;
            lk_hit      <= 1'b1;
            lk_peer_qp  <= cur.peer_qp;
            lk_peer_ip  <= cur.peer_ip;
            lk_peer_mac <= cur.peer_mac;
          end else if (lk_last) begin
            lk_busy     <= 1'b0;
            lk_done     <= 1'b1;
            lk_hit      <= 1'b0;
            lk_peer_qp  <= '0;
            lk_peer_ip  <= '0;
            lk_peer_mac <= '0;
          end else begin
            lk_k <= lk_k + 6'd1;
          end
        end
      end
    end
  end
endmodule
